param_router_arb: RTL and testbench
===================================

Name: param_router_arb

Overview:
- Parametrised successor to the 4-bank cache parameter router.
- Routes a processor port and a user port onto N_CACHE cache banks.
- Bank selection is held in registers, not driven combinationally.
- A processor bank switch requested during a critical section is deferred, then applied through a guarded switch cycle.
- Concurrent user and processor access to the same bank is arbitrated by `critical`.
- Sits between the neuron processor, the host/user interface and the cache bank array.

Parameters:
- N_CACHE, 4, number of cache banks; must be at least 2.
- DATA_W, 16, data width.
- ADDR_W, 16, address width.
- SEL_W, $clog2(N_CACHE), width of the bank select fields.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- critical  in  1  processor is in a critical section.
- sel_req  in  SEL_W  requested processor bank.
- sel_req_valid  in  1  one-cycle request strobe that latches `sel_req`.
- switch_done  out  1  one-cycle pulse when the new processor bank becomes active.
- active_sel  out  SEL_W  bank currently owned by the processor.
- switch_pending  out  1  a switch request is waiting to be applied.
- proce_Addr, proce_DataIn  in  ADDR_W, DATA_W  processor address and write data.
- proce_WE  in  1  processor write enable.
- proce_DataOut  out  DATA_W  processor read data, registered.
- proce_stall  out  1  processor access blocked this cycle.
- user_sel  in  SEL_W  bank targeted by the user port.
- user_Addr, user_DataIn  in  ADDR_W, DATA_W  user address and write data.
- user_WE  in  1  user write enable.
- user_DataOut  out  DATA_W  user read data, registered.
- user_stall  out  1  user access blocked this cycle.
- cache_Addr  out  N_CACHE*ADDR_W  per-bank address; bank k occupies slice [k*ADDR_W +: ADDR_W].
- cache_DataIn  out  N_CACHE*DATA_W  per-bank write data.
- cache_WE  out  N_CACHE  per-bank write enable.
- cache_DataOut  in  N_CACHE*DATA_W  per-bank read data.

Behaviour:
- Reset values: active_sel=0, FSM=IDLE, switch_pending=0, switch_done=0, proce_DataOut=0, user_DataOut=0. All cache_WE=0 in the reset cycle.
- FSM has three states: IDLE, PENDING, GUARD.
  - IDLE: on sel_req_valid, latch sel_req into next_sel.
    - If critical=0, go to GUARD.
    - If critical=1, go to PENDING.
    - If sel_req equals active_sel, stay in IDLE and pulse switch_done on the next cycle; no GUARD cycle.
  - PENDING: switch_pending=1. A new sel_req_valid overwrites next_sel; the latest request wins. When critical=0 is sampled, go to GUARD.
  - GUARD: lasts exactly one cycle with all cache_WE=0 and proce_stall=user_stall=1. On exit, active_sel<=next_sel, switch_done=1 for one cycle, return to IDLE.
  - A sel_req_valid arriving in GUARD is latched and restarts the FSM from IDLE after the switch completes.
- Routing (combinational from the registered active_sel and from user_sel):
  - Processor drives bank active_sel.
  - User drives bank user_sel.
  - Banks addressed by neither port get Addr=0, DataIn=0, WE=0.
- Conflict when user_sel==active_sel:
  - critical=1: processor wins; user_stall=1 and user writes are dropped.
  - critical=0: user wins; proce_stall=1 and processor writes are dropped.
  - A stalled port's DataOut holds its previous value.
- Read latency: DataOut is registered and equals cache_DataOut of the port's routed bank one cycle after that bank is addressed.
- Out-of-range user_sel (≥N_CACHE): no bank is driven, user_stall=1, user_DataOut holds.
- rst asserted mid-switch: PENDING or GUARD is abandoned, next_sel is discarded, active_sel returns to 0.

Optional Feature:
- Macro: ROUTER_STATS_EN.
- Defined: adds output conflict_cnt [15:0]. It increments once per cycle in which either stall is caused by a user/processor conflict, saturates at 16'hFFFF, and resets to 0.
- Undefined: the port and its counter logic are absent. All other behaviour is identical.

Test Plan:
- Basic routing:
  - Stimulus: reset; cache_DataOut banks = AAAA/BBBB/CCCC/DDDD; critical=0; user_sel=2; proce_Addr=EEEE; proce_WE=1.
  - Required: bank0 gets Addr EEEE and WE=1; bank2 gets user_Addr FFFF. One cycle later proce_DataOut=AAAA and user_DataOut=CCCC.
- Switch outside a critical section:
  - Stimulus: sel_req=3, sel_req_valid at cycle t, critical=0.
  - Required: GUARD at t+1 with all WE=0; active_sel=3 and switch_done=1 at t+2; proce_DataOut=DDDD at t+3.
- Deferred switch:
  - Stimulus: critical=1; sel_req=1 pulsed; critical held 5 cycles; sel_req=2 pulsed in between; then critical=0.
  - Required: switch_pending=1 throughout; active_sel stays 0; after critical falls, one GUARD cycle, then active_sel=2.
- Conflict arbitration:
  - Stimulus: user_sel=active_sel=1; both WE=1.
  - Required: with critical=1, bank1 WE from the processor and user_stall=1; with critical=0, the user writes and proce_stall=1.
  - With ROUTER_STATS_EN defined: conflict_cnt increments by 2 over those two cycles.
- Reset mid-switch:
  - Stimulus: assert rst during PENDING.
  - Required: switch_pending=0, active_sel=0, no switch_done pulse after reset release.
- Out-of-range user_sel:
  - Stimulus: N_CACHE=3, user_sel=3.
  - Required: user_stall=1, no bank WE from the user, user_DataOut unchanged.

Source files
------------

// File: rtl/param_router_arb.sv
// Parametrised cache bank router: a processor port and a user port share N_CACHE banks.
// Define ROUTER_STATS_EN to add the saturating conflict_cnt output.
module param_router_arb #(
    parameter int N_CACHE = 4,
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int SEL_W   = $clog2(N_CACHE)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      critical,
    input  logic [SEL_W-1:0]          sel_req,
    input  logic                      sel_req_valid,
    output logic                      switch_done,
    output logic [SEL_W-1:0]          active_sel,
    output logic                      switch_pending,
    input  logic [ADDR_W-1:0]         proce_Addr,
    input  logic [DATA_W-1:0]         proce_DataIn,
    input  logic                      proce_WE,
    output logic [DATA_W-1:0]         proce_DataOut,
    output logic                      proce_stall,
    input  logic [SEL_W-1:0]          user_sel,
    input  logic [ADDR_W-1:0]         user_Addr,
    input  logic [DATA_W-1:0]         user_DataIn,
    input  logic                      user_WE,
    output logic [DATA_W-1:0]         user_DataOut,
    output logic                      user_stall,
    output logic [N_CACHE*ADDR_W-1:0] cache_Addr,
    output logic [N_CACHE*DATA_W-1:0] cache_DataIn,
    output logic [N_CACHE-1:0]        cache_WE,
    input  logic [N_CACHE*DATA_W-1:0] cache_DataOut
`ifdef ROUTER_STATS_EN
    ,
    output logic [15:0]               conflict_cnt
`endif
);

    localparam logic [SEL_W:0] N_LIMIT = (SEL_W+1)'(N_CACHE);

    typedef enum logic [1:0] {IDLE, PENDING, GUARD} state_t;

    state_t           state;
    logic [SEL_W-1:0] next_sel;
    logic [SEL_W-1:0] held_sel;
    logic             held_valid;

    logic             guard;
    logic             user_in_range;
    logic             req_in_range;
    logic             conflict;
    logic             user_owns;
    logic             block_we;
    logic             req_any;
    logic [SEL_W-1:0] req_sel;
    logic             req_sel_ok;
    logic [DATA_W-1:0] proce_rd;
    logic [DATA_W-1:0] user_rd;

    assign guard         = (state == GUARD);
    assign user_in_range = ({1'b0, user_sel} < N_LIMIT);
    assign req_in_range  = ({1'b0, sel_req} < N_LIMIT);
    assign conflict      = user_in_range && (user_sel == active_sel);
    assign user_owns     = user_in_range && !(conflict && critical);
    assign block_we      = guard || rst;

    assign proce_stall = guard || (conflict && !critical);
    assign user_stall  = guard || !user_in_range || (conflict && critical);

    // A request caught during GUARD is replayed from IDLE; a fresh strobe supersedes it.
    assign req_any    = sel_req_valid || held_valid;
    assign req_sel    = sel_req_valid ? sel_req : held_sel;
    assign req_sel_ok = sel_req_valid ? req_in_range : 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            active_sel     <= '0;
            next_sel       <= '0;
            held_sel       <= '0;
            held_valid     <= 1'b0;
            switch_pending <= 1'b0;
            switch_done    <= 1'b0;
        end else begin
            switch_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_any) begin
                        held_valid <= 1'b0;
                        if (req_sel_ok) begin
                            if (req_sel == active_sel) begin
                                switch_done <= 1'b1;
                            end else begin
                                next_sel <= req_sel;
                                if (critical) begin
                                    state          <= PENDING;
                                    switch_pending <= 1'b1;
                                end else begin
                                    state <= GUARD;
                                end
                            end
                        end
                    end
                end
                PENDING: begin
                    if (sel_req_valid && req_in_range) begin
                        next_sel <= sel_req;
                    end
                    if (!critical) begin
                        state          <= GUARD;
                        switch_pending <= 1'b0;
                    end
                end
                GUARD: begin
                    active_sel  <= next_sel;
                    switch_done <= 1'b1;
                    state       <= IDLE;
                    if (sel_req_valid && req_in_range) begin
                        held_valid <= 1'b1;
                        held_sel   <= sel_req;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Bank fan-out: the conflict winner owns a shared bank; untouched banks stay at zero.
    always_comb begin
        cache_Addr   = '0;
        cache_DataIn = '0;
        cache_WE     = '0;
        for (int k = 0; k < N_CACHE; k++) begin
            if (user_owns && (user_sel == SEL_W'(k))) begin
                cache_Addr[k*ADDR_W +: ADDR_W]   = user_Addr;
                cache_DataIn[k*DATA_W +: DATA_W] = user_DataIn;
                cache_WE[k]                      = user_WE && !block_we;
            end else if (active_sel == SEL_W'(k)) begin
                cache_Addr[k*ADDR_W +: ADDR_W]   = proce_Addr;
                cache_DataIn[k*DATA_W +: DATA_W] = proce_DataIn;
                cache_WE[k]                      = proce_WE && !block_we;
            end
        end
    end

    always_comb begin
        proce_rd = '0;
        user_rd  = '0;
        for (int k = 0; k < N_CACHE; k++) begin
            if (active_sel == SEL_W'(k)) proce_rd = cache_DataOut[k*DATA_W +: DATA_W];
            if (user_sel == SEL_W'(k))   user_rd  = cache_DataOut[k*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            proce_DataOut <= '0;
            user_DataOut  <= '0;
        end else begin
            if (!proce_stall) proce_DataOut <= proce_rd;
            if (!user_stall)  user_DataOut  <= user_rd;
        end
    end

`ifdef ROUTER_STATS_EN
    // GUARD stalls are not conflicts, so they are excluded from the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_cnt <= '0;
        end else if (conflict && !guard && (conflict_cnt != 16'hFFFF)) begin
            conflict_cnt <= conflict_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_param_router_arb.sv
// Directed self-checking bench for param_router_arb (4-bank instance plus a 3-bank instance).
module tb_param_router_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        critical;
    logic [1:0]  sel_req;
    logic        sel_req_valid;
    logic [15:0] proce_Addr, proce_DataIn, user_Addr, user_DataIn;
    logic        proce_WE, user_WE;
    logic [1:0]  user_sel, user_sel3;
    logic [63:0] cache_DataOut;
    logic [47:0] cache_DataOut3;

    logic        switch_done, switch_pending, proce_stall, user_stall;
    logic [1:0]  active_sel;
    logic [15:0] proce_DataOut, user_DataOut;
    logic [63:0] cache_Addr, cache_DataIn;
    logic [3:0]  cache_WE;

    logic        switch_done3, switch_pending3, proce_stall3, user_stall3;
    logic [1:0]  active_sel3;
    logic [15:0] proce_DataOut3, user_DataOut3;
    logic [47:0] cache_Addr3, cache_DataIn3;
    logic [2:0]  cache_WE3;
`ifdef ROUTER_STATS_EN
    logic [15:0] conflict_cnt, conflict_cnt3;
`endif

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    param_router_arb #(.N_CACHE(4), .DATA_W(16), .ADDR_W(16)) dut (
        .clk(clk), .rst(rst), .critical(critical), .sel_req(sel_req),
        .sel_req_valid(sel_req_valid), .switch_done(switch_done),
        .active_sel(active_sel), .switch_pending(switch_pending),
        .proce_Addr(proce_Addr), .proce_DataIn(proce_DataIn), .proce_WE(proce_WE),
        .proce_DataOut(proce_DataOut), .proce_stall(proce_stall),
        .user_sel(user_sel), .user_Addr(user_Addr), .user_DataIn(user_DataIn),
        .user_WE(user_WE), .user_DataOut(user_DataOut), .user_stall(user_stall),
        .cache_Addr(cache_Addr), .cache_DataIn(cache_DataIn), .cache_WE(cache_WE),
        .cache_DataOut(cache_DataOut)
`ifdef ROUTER_STATS_EN
        , .conflict_cnt(conflict_cnt)
`endif
    );

    param_router_arb #(.N_CACHE(3), .DATA_W(16), .ADDR_W(16)) dut3 (
        .clk(clk), .rst(rst), .critical(critical), .sel_req(sel_req),
        .sel_req_valid(sel_req_valid), .switch_done(switch_done3),
        .active_sel(active_sel3), .switch_pending(switch_pending3),
        .proce_Addr(proce_Addr), .proce_DataIn(proce_DataIn), .proce_WE(proce_WE),
        .proce_DataOut(proce_DataOut3), .proce_stall(proce_stall3),
        .user_sel(user_sel3), .user_Addr(user_Addr), .user_DataIn(user_DataIn),
        .user_WE(user_WE), .user_DataOut(user_DataOut3), .user_stall(user_stall3),
        .cache_Addr(cache_Addr3), .cache_DataIn(cache_DataIn3), .cache_WE(cache_WE3),
        .cache_DataOut(cache_DataOut3)
`ifdef ROUTER_STATS_EN
        , .conflict_cnt(conflict_cnt3)
`endif
    );

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic crit, input logic [1:0] usel,
                                 input logic pwe, input logic uwe);
        critical = crit;
        user_sel = usel;
        proce_WE = pwe;
        user_WE  = uwe;
        #1;
    endtask

    initial begin
        rst = 1'b1; critical = 1'b0; sel_req = 2'd0; sel_req_valid = 1'b0;
        proce_Addr = 16'hEEEE; proce_DataIn = 16'h1234;
        user_Addr = 16'hFFFF;  user_DataIn = 16'h5678;
        proce_WE = 1'b1; user_WE = 1'b1; user_sel = 2'd2; user_sel3 = 2'd0;
        cache_DataOut  = 64'hDDDD_CCCC_BBBB_AAAA;
        cache_DataOut3 = 48'hCCCC_BBBB_AAAA;

        // Reset state
        tick(); tick();
        checkOutput("rst_active_sel", active_sel, 0);
        checkOutput("rst_pending", switch_pending, 0);
        checkOutput("rst_done", switch_done, 0);
        checkOutput("rst_proce_dout", proce_DataOut, 0);
        checkOutput("rst_user_dout", user_DataOut, 0);
        checkOutput("rst_cache_we", cache_WE, 0);
`ifdef ROUTER_STATS_EN
        checkOutput("rst_conflict_cnt", conflict_cnt, 0);
`endif

        // Basic routing
        rst = 1'b0;
        applyStimulus(1'b0, 2'd2, 1'b1, 1'b0);
        checkOutput("route_b0_addr", cache_Addr[15:0], 16'hEEEE);
        checkOutput("route_b2_addr", cache_Addr[47:32], 16'hFFFF);
        checkOutput("route_b1_addr", cache_Addr[31:16], 16'h0000);
        checkOutput("route_we", cache_WE, 4'b0001);
        checkOutput("route_stalls", {proce_stall, user_stall}, 2'b00);
        tick();
        checkOutput("route_proce_dout", proce_DataOut, 16'hAAAA);
        checkOutput("route_user_dout", user_DataOut, 16'hCCCC);

        // Switch outside a critical section
        applyStimulus(1'b0, 2'd2, 1'b1, 1'b1);
        sel_req = 2'd3; sel_req_valid = 1'b1;
        tick();
        sel_req_valid = 1'b0; #1;
        checkOutput("guard_we", cache_WE, 4'b0000);
        checkOutput("guard_stalls", {proce_stall, user_stall}, 2'b11);
        checkOutput("guard_active", active_sel, 0);
        tick();
        checkOutput("sw_active", active_sel, 3);
        checkOutput("sw_done", switch_done, 1);
        checkOutput("sw_proce_hold", proce_DataOut, 16'hAAAA);
        checkOutput("sw_we_after", cache_WE, 4'b1100);
        tick();
        checkOutput("sw_proce_dout", proce_DataOut, 16'hDDDD);
        checkOutput("sw_done_clear", switch_done, 0);

        // Request for the bank already owned: immediate done, no GUARD
        sel_req = 2'd3; sel_req_valid = 1'b1;
        tick();
        sel_req_valid = 1'b0; #1;
        checkOutput("same_done", switch_done, 1);
        checkOutput("same_no_guard", cache_WE, 4'b1100);
        tick();
        checkOutput("same_done_clear", switch_done, 0);

        // Deferred switch; latest request wins
        applyStimulus(1'b1, 2'd0, 1'b1, 1'b0);
        sel_req = 2'd1; sel_req_valid = 1'b1;
        tick();
        sel_req_valid = 1'b0; #1;
        checkOutput("defer_pending1", switch_pending, 1);
        tick();
        checkOutput("defer_pending2", switch_pending, 1);
        sel_req = 2'd2; sel_req_valid = 1'b1;
        tick();
        sel_req_valid = 1'b0; #1;
        checkOutput("defer_active_hold", active_sel, 3);
        tick(); tick();
        checkOutput("defer_pending3", switch_pending, 1);
        checkOutput("defer_no_done", switch_done, 0);
        critical = 1'b0;
        tick();
        checkOutput("defer_guard_we", cache_WE, 4'b0000);
        checkOutput("defer_guard_pending", switch_pending, 0);
        checkOutput("defer_guard_active", active_sel, 3);
        tick();
        checkOutput("defer_active", active_sel, 2);
        checkOutput("defer_done", switch_done, 1);
        sel_req = 2'd1; sel_req_valid = 1'b1;
        tick();
        sel_req_valid = 1'b0;
        tick();
        checkOutput("to_bank1_active", active_sel, 1);
        checkOutput("user_dout_bank0", user_DataOut, 16'hAAAA);

        // Conflict arbitration on bank 1
        cache_DataOut = 64'hDDDD_CCCC_1111_AAAA;
        applyStimulus(1'b1, 2'd1, 1'b1, 1'b1);
        checkOutput("crit1_we", cache_WE, 4'b0010);
        checkOutput("crit1_addr", cache_Addr[31:16], 16'hEEEE);
        checkOutput("crit1_data", cache_DataIn[31:16], 16'h1234);
        checkOutput("crit1_stalls", {proce_stall, user_stall}, 2'b01);
        tick();
        checkOutput("crit1_proce_dout", proce_DataOut, 16'h1111);
        checkOutput("crit1_user_hold", user_DataOut, 16'hAAAA);
        cache_DataOut = 64'hDDDD_CCCC_2222_AAAA;
        applyStimulus(1'b0, 2'd1, 1'b1, 1'b1);
        checkOutput("crit0_we", cache_WE, 4'b0010);
        checkOutput("crit0_addr", cache_Addr[31:16], 16'hFFFF);
        checkOutput("crit0_data", cache_DataIn[31:16], 16'h5678);
        checkOutput("crit0_stalls", {proce_stall, user_stall}, 2'b10);
        tick();
        checkOutput("crit0_user_dout", user_DataOut, 16'h2222);
        checkOutput("crit0_proce_hold", proce_DataOut, 16'h1111);
`ifdef ROUTER_STATS_EN
        checkOutput("conflict_cnt", conflict_cnt, 2);
`endif

        // Reset during PENDING
        applyStimulus(1'b1, 2'd2, 1'b1, 1'b0);
        sel_req = 2'd3; sel_req_valid = 1'b1;
        tick();
        sel_req_valid = 1'b0; #1;
        checkOutput("mid_pending", switch_pending, 1);
        rst = 1'b1;
        tick();
        checkOutput("mid_rst_pending", switch_pending, 0);
        checkOutput("mid_rst_active", active_sel, 0);
        rst = 1'b0; critical = 1'b0;
        tick();
        checkOutput("mid_no_done1", switch_done, 0);
        tick();
        checkOutput("mid_no_done2", switch_done, 0);
        checkOutput("mid_active", active_sel, 0);
        checkOutput("mid_we", cache_WE, 4'b0001);

        // Out-of-range user_sel on the 3-bank instance
        applyStimulus(1'b0, 2'd2, 1'b0, 1'b1);
        user_sel3 = 2'd1; #1;
        checkOutput("n3_we_inrange", cache_WE3, 3'b010);
        tick();
        checkOutput("n3_user_dout", user_DataOut3, 16'hBBBB);
        user_sel3 = 2'd3; #1;
        checkOutput("n3_oob_stall", user_stall3, 1);
        checkOutput("n3_oob_we", cache_WE3, 3'b000);
        tick();
        checkOutput("n3_oob_hold", user_DataOut3, 16'hBBBB);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
